coffee_order_ctrl: RTL and testbench
====================================

// Module: coffee_order_ctrl
// PURPOSE
//  Upstream front end of coffee_maker: accepts coins, latches the drink/sugar
//  selection, checks credit against the per-flavour price, then presents a
//  stable order (flavour_select, sugar_select, order_valid) until coffee_maker
//  reports done. Returns leftover credit as unit change pulses; handles cancel
//  and an inactivity timeout.
// PARAMETERS
//  PRICE_ESP    8'd20  espresso price, credit units (flavour code 2'b00)
//  PRICE_CAP    8'd30  cappuccino price (2'b01)
//  PRICE_LAT    8'd30  latte price (2'b10)
//  PRICE_MOC    8'd35  mocha price (2'b11)
//  CREDIT_MAX   8'd200 credit ceiling; a coin that would exceed it is rejected
//  TIMEOUT_CYC  1000   idle cycles in SELECTED before auto-refund
// PORTS
//  clk             in   1  system clock, rising edge
//  rst_n           in   1  reset, asynchronous, active-low
//  coin_valid      in   1  one-cycle pulse: coin present
//  coin_value      in   4  coin value in credit units, sampled with coin_valid
//  flavour_btn     in   4  one-hot press, bit0=esp bit1=cap bit2=lat bit3=moc
//  sugar_level     in   2  sugar setting, sampled with a valid flavour_btn
//  cancel          in   1  one-cycle pulse: abort and refund
//  maker_done      in   1  from coffee_maker done: drink complete
//  flavour_select  out  2  latched flavour code to coffee_maker
//  sugar_select    out  2  latched sugar code to coffee_maker
//  order_valid     out  1  high while order is handed to coffee_maker
//  credit          out  8  current credit balance
//  coin_reject     out  1  one-cycle pulse: coin refused
//  change_pulse    out  1  one pulse per credit unit returned
//  busy            out  1  high in BREW or REFUND
// BEHAVIOUR
//  Reset (async on rst_n low): state IDLE; every output 0; timer cleared.
//  States IDLE, SELECTED, BREW, REFUND. All outputs registered.
//  Coins, IDLE/SELECTED: credit += coin_value next cycle, 8-bit add;
//   if sum > CREDIT_MAX, credit unchanged and coin_reject pulses.
//   BREW/REFUND: every coin rejected.
//  flavour_btn: counted only when exactly one bit set; 0 or >1 bits ignored.
//  IDLE: valid press latches flavour/sugar -> SELECTED; cancel with
//   credit>0 -> REFUND; cancel with credit==0 ignored.
//  SELECTED: credit >= price(flavour) -> BREW, credit -= price in same update.
//   Valid press re-latches flavour/sugar; cancel -> REFUND; timer expiry -> REFUND.
//   Timer reloads on entry, every coin and every valid press.
//  Latency: press at edge N -> SELECTED at N+1 -> order_valid=1 at N+2
//   if credit is already sufficient.
//  BREW: order_valid=1; flavour_select/sugar_select frozen; buttons and cancel
//   ignored. maker_done -> order_valid=0 next cycle, then REFUND if credit>0,
//   else IDLE.
//  REFUND: change_pulse high 1 cycle, low 1 cycle, repeating; credit -1 per
//   pulse; IDLE on the cycle after credit reaches 0. Pulse count == credit at entry.
//  Simultaneous events:
//   coin+press in IDLE: both take effect.
//   coin+cancel: coin added first, then whole credit refunded.
//   press+cancel: cancel wins.
//   maker_done outside BREW: ignored.
//  Reset mid-operation: order aborted, credit discarded, no change pulses.
// STRUCTURE
//  Shared package coffee_pkg: state encoding, flavour codes 2'b00..2'b11,
//   default prices, CREDIT_W=8.
//  Sub-module coffee_order_timer: loadable down-counter with expiry pulse.
//  Price mux and credit arithmetic stay inline.
// TESTING
//  1 coins 10,10, press latte, coin 10 -> order_valid, flavour_select=2'b10,
//    credit=0; maker_done -> IDLE, zero change_pulse.
//  2 coins 10,10,10, press esp -> credit=10 during BREW;
//    maker_done -> 10 change_pulse on alternate cycles, credit=0, IDLE.
//  3 coin 15, cancel -> 15 change_pulse, order_valid never high.
//  4 press mocha (sugar 2'b11), coin 10, idle TIMEOUT_CYC cycles ->
//    10 change_pulse, IDLE.
//  5 credit 195, coin 10 -> coin_reject, credit stays 195;
//    coin 5 during BREW -> coin_reject, credit unchanged.
//  6 rst_n low mid-BREW -> order_valid, credit, busy all 0 before next edge;
//    state IDLE after release.

Source files
------------

// File: rtl/coffee_pkg.sv
// Shared types and defaults for the coffee order front end.
package coffee_pkg;

    localparam int unsigned CREDIT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECTED,
        ST_BREW,
        ST_REFUND
    } state_t;

    typedef enum logic [1:0] {
        FLV_ESP = 2'b00,
        FLV_CAP = 2'b01,
        FLV_LAT = 2'b10,
        FLV_MOC = 2'b11
    } flavour_t;

    localparam logic [CREDIT_W-1:0] PRICE_ESP_DEF  = 8'd20;
    localparam logic [CREDIT_W-1:0] PRICE_CAP_DEF  = 8'd30;
    localparam logic [CREDIT_W-1:0] PRICE_LAT_DEF  = 8'd30;
    localparam logic [CREDIT_W-1:0] PRICE_MOC_DEF  = 8'd35;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX_DEF = 8'd200;
    localparam int unsigned         TIMEOUT_DEF    = 1000;

    function automatic logic btn_valid(input logic [3:0] btn);
        return $onehot(btn);
    endfunction

    function automatic flavour_t btn_code(input logic [3:0] btn);
        flavour_t code;
        code = FLV_ESP;
        case (btn)
            4'b0010: code = FLV_CAP;
            4'b0100: code = FLV_LAT;
            4'b1000: code = FLV_MOC;
            default: code = FLV_ESP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/coffee_order_timer.sv
// Loadable down-counter; expire_o is high during the last enabled count.
module coffee_order_timer #(
    parameter int unsigned LOAD_VAL = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(LOAD_VAL);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of load_i so the controller can gate it without a comb loop.
    assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/coffee_order_ctrl.sv
// Coin/selection front end for coffee_maker: credit, order hand-off, refund.
module coffee_order_ctrl
    import coffee_pkg::*;
#(
    parameter logic [CREDIT_W-1:0] PRICE_ESP   = PRICE_ESP_DEF,
    parameter logic [CREDIT_W-1:0] PRICE_CAP   = PRICE_CAP_DEF,
    parameter logic [CREDIT_W-1:0] PRICE_LAT   = PRICE_LAT_DEF,
    parameter logic [CREDIT_W-1:0] PRICE_MOC   = PRICE_MOC_DEF,
    parameter logic [CREDIT_W-1:0] CREDIT_MAX  = CREDIT_MAX_DEF,
    parameter int unsigned         TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    input  logic [3:0]          flavour_btn,
    input  logic [1:0]          sugar_level,
    input  logic                cancel,
    input  logic                maker_done,
    output logic [1:0]          flavour_select,
    output logic [1:0]          sugar_select,
    output logic                order_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_pulse,
    output logic                busy
);

    state_t                state_q, state_d;
    flavour_t              flavour_q, flavour_d;
    logic [1:0]            sugar_q, sugar_d;
    logic                  order_valid_q, order_valid_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  change_pulse_q, change_pulse_d;
    logic                  busy_q, busy_d;

    logic                  press_ok;
    flavour_t              flavour_eff;
    logic [CREDIT_W-1:0]   price;
    logic [CREDIT_W:0]     coin_sum;
    logic                  coin_ok;
    logic [CREDIT_W-1:0]   credit_add;
    logic                  timer_load;
    logic                  timer_expire;

    coffee_order_timer #(
        .LOAD_VAL (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .en_i     (state_q == ST_SELECTED),
        .expire_o (timer_expire)
    );

    always_comb begin
        press_ok    = btn_valid(flavour_btn);
        flavour_eff = press_ok ? btn_code(flavour_btn) : flavour_q;
        case (flavour_eff)
            FLV_ESP: price = PRICE_ESP;
            FLV_CAP: price = PRICE_CAP;
            FLV_LAT: price = PRICE_LAT;
            default: price = PRICE_MOC;
        endcase
        coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value);
        coin_ok    = coin_valid && (coin_sum <= {1'b0, CREDIT_MAX});
        credit_add = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    end

    always_comb begin
        state_d        = state_q;
        flavour_d      = flavour_q;
        sugar_d        = sugar_q;
        credit_d       = credit_q;
        order_valid_d  = 1'b0;
        coin_reject_d  = 1'b0;
        change_pulse_d = 1'b0;
        timer_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                coin_reject_d = coin_valid && !coin_ok;
                credit_d      = credit_add;
                if (cancel && (credit_add != '0)) begin
                    state_d = ST_REFUND;
                end else if (press_ok) begin
                    flavour_d  = flavour_eff;
                    sugar_d    = sugar_level;
                    state_d    = ST_SELECTED;
                    timer_load = 1'b1;
                end
            end
            ST_SELECTED: begin
                coin_reject_d = coin_valid && !coin_ok;
                credit_d      = credit_add;
                if (cancel) begin
                    state_d = ST_REFUND;
                end else begin
                    if (press_ok) begin
                        flavour_d = flavour_eff;
                        sugar_d   = sugar_level;
                    end
                    // A coin or press in the expiry cycle restarts the timeout.
                    if (credit_add >= price) begin
                        state_d       = ST_BREW;
                        credit_d      = credit_add - price;
                        order_valid_d = 1'b1;
                    end else if (coin_valid || press_ok) begin
                        timer_load = 1'b1;
                    end else if (timer_expire) begin
                        state_d = ST_REFUND;
                    end
                end
            end
            ST_BREW: begin
                coin_reject_d = coin_valid;
                order_valid_d = 1'b1;
                if (maker_done) begin
                    order_valid_d = 1'b0;
                    state_d       = (credit_q != '0) ? ST_REFUND : ST_IDLE;
                end
            end
            ST_REFUND: begin
                coin_reject_d = coin_valid;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (!change_pulse_q) begin
                    change_pulse_d = 1'b1;
                    credit_d       = credit_q - CREDIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_BREW) || (state_d == ST_REFUND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            flavour_q      <= FLV_ESP;
            sugar_q        <= '0;
            credit_q       <= '0;
            order_valid_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            change_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            flavour_q      <= flavour_d;
            sugar_q        <= sugar_d;
            credit_q       <= credit_d;
            order_valid_q  <= order_valid_d;
            coin_reject_q  <= coin_reject_d;
            change_pulse_q <= change_pulse_d;
            busy_q         <= busy_d;
        end
    end

    assign flavour_select = flavour_q;
    assign sugar_select   = sugar_q;
    assign order_valid    = order_valid_q;
    assign credit         = credit_q;
    assign coin_reject    = coin_reject_q;
    assign change_pulse   = change_pulse_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_coffee_order_ctrl.sv
// Directed bench for coffee_order_ctrl with hand-computed expectations.
module tb_coffee_order_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic [3:0] flavour_btn;
    logic [1:0] sugar_level;
    logic       cancel;
    logic       maker_done;
    logic [1:0] flavour_select;
    logic [1:0] sugar_select;
    logic       order_valid;
    logic [7:0] credit;
    logic       coin_reject;
    logic       change_pulse;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int adj_err   = 0;
    int ov_cnt    = 0;
    logic prev_pulse = 1'b0;

    int base;
    int ov_base;
    int n;

    always #5 clk = ~clk;

    coffee_order_ctrl #(
        .TIMEOUT_CYC (1000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .flavour_btn    (flavour_btn),
        .sugar_level    (sugar_level),
        .cancel         (cancel),
        .maker_done     (maker_done),
        .flavour_select (flavour_select),
        .sugar_select   (sugar_select),
        .order_valid    (order_valid),
        .credit         (credit),
        .coin_reject    (coin_reject),
        .change_pulse   (change_pulse),
        .busy           (busy)
    );

    // Each change pulse is one full cycle, so mid-cycle sampling counts it once.
    always @(negedge clk) begin
        if (change_pulse) pulse_cnt++;
        if (change_pulse && prev_pulse) adj_err++;
        if (order_valid) ov_cnt++;
        prev_pulse = change_pulse;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic press(input logic [3:0] b, input logic [1:0] s);
        flavour_btn = b;
        sugar_level = s;
        tick();
        flavour_btn = '0;
        sugar_level = '0;
    endtask

    task automatic done_pulse();
        maker_done = 1'b1;
        tick();
        maker_done = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 2000) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        coin_valid  = 1'b0;
        coin_value  = '0;
        flavour_btn = '0;
        sugar_level = '0;
        cancel      = 1'b0;
        maker_done  = 1'b0;
        tick();
        tick();
        check("rst_credit", 32'(credit), 0);
        check("rst_order_valid", 32'(order_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_change", 32'(change_pulse), 0);
        check("rst_reject", 32'(coin_reject), 0);
        check("rst_flavour", 32'(flavour_select), 0);
        check("rst_sugar", 32'(sugar_select), 0);
        rst_n = 1'b1;
        tick();

        // 1: exact credit for latte, no change
        coin(4'd10);
        check("t1_credit10", 32'(credit), 10);
        coin(4'd10);
        press(4'b0100, 2'b01);
        check("t1_ov_short", 32'(order_valid), 0);
        coin(4'd10);
        check("t1_ov", 32'(order_valid), 1);
        check("t1_flavour", 32'(flavour_select), 2);
        check("t1_sugar", 32'(sugar_select), 1);
        check("t1_credit", 32'(credit), 0);
        check("t1_busy", 32'(busy), 1);
        base = pulse_cnt;
        done_pulse();
        check("t1_ov_off", 32'(order_valid), 0);
        check("t1_idle", 32'(busy), 0);
        repeat (10) tick();
        check("t1_no_change", 32'(pulse_cnt - base), 0);

        // 2: espresso with 10 change, frozen selection during brew
        coin(4'd10);
        coin(4'd10);
        coin(4'd10);
        press(4'b0001, 2'b00);
        check("t2_ov_latency", 32'(order_valid), 0);
        tick();
        check("t2_ov", 32'(order_valid), 1);
        check("t2_credit_brew", 32'(credit), 10);
        press(4'b0010, 2'b10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t2_flavour_frozen", 32'(flavour_select), 0);
        check("t2_sugar_frozen", 32'(sugar_select), 0);
        check("t2_ov_held", 32'(order_valid), 1);
        check("t2_credit_held", 32'(credit), 10);
        base = pulse_cnt;
        done_pulse();
        check("t2_refund_busy", 32'(busy), 1);
        check("t2_ov_off", 32'(order_valid), 0);
        wait_idle(n);
        check("t2_refund_cycles", 32'(n), 20);
        check("t2_pulses", 32'(pulse_cnt - base), 10);
        check("t2_credit_end", 32'(credit), 0);
        check("t2_alternate", 32'(adj_err), 0);

        // 3: cancel refunds without an order
        ov_base = ov_cnt;
        base = pulse_cnt;
        coin(4'd15);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t3_busy", 32'(busy), 1);
        wait_idle(n);
        check("t3_cycles", 32'(n), 30);
        check("t3_pulses", 32'(pulse_cnt - base), 15);
        check("t3_no_order", 32'(ov_cnt - ov_base), 0);

        // 4: inactivity timeout refunds
        press(4'b1000, 2'b11);
        check("t4_flavour", 32'(flavour_select), 3);
        check("t4_sugar", 32'(sugar_select), 3);
        coin(4'd10);
        check("t4_credit", 32'(credit), 10);
        base = pulse_cnt;
        n = 0;
        while (!busy && n < 1100) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 1000);
        wait_idle(n);
        check("t4_pulses", 32'(pulse_cnt - base), 10);
        check("t4_credit_end", 32'(credit), 0);

        // 5: credit ceiling and coins during brew
        repeat (13) coin(4'd15);
        check("t5_credit195", 32'(credit), 195);
        coin(4'd10);
        check("t5_reject", 32'(coin_reject), 1);
        check("t5_credit_kept", 32'(credit), 195);
        tick();
        check("t5_reject_pulse", 32'(coin_reject), 0);
        coin(4'd5);
        check("t5_at_max", 32'(credit), 200);
        check("t5_max_accepted", 32'(coin_reject), 0);
        press(4'b0001, 2'b00);
        tick();
        check("t5_credit_brew", 32'(credit), 180);
        coin(4'd5);
        check("t5_brew_reject", 32'(coin_reject), 1);
        check("t5_brew_credit", 32'(credit), 180);
        check("t5_brew_ov", 32'(order_valid), 1);

        // 6: asynchronous reset mid-brew
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_ov", 32'(order_valid), 0);
        check("t6_credit", 32'(credit), 0);
        check("t6_busy", 32'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        base = pulse_cnt;
        repeat (5) tick();
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_no_change", 32'(pulse_cnt - base), 0);
        check("t6_idle_credit", 32'(credit), 0);

        // 7: multi-bit press ignored, then press-to-order latency
        coin(4'd10);
        coin(4'd10);
        press(4'b0011, 2'b01);
        tick();
        check("t7_bad_press", 32'(order_valid), 0);
        press(4'b0001, 2'b10);
        check("t7_latency_n1", 32'(order_valid), 0);
        tick();
        check("t7_latency_n2", 32'(order_valid), 1);
        check("t7_sugar", 32'(sugar_select), 2);
        check("t7_credit", 32'(credit), 0);
        done_pulse();
        check("t7_idle", 32'(busy), 0);

        // 8: coin and cancel together from zero credit
        base = pulse_cnt;
        coin_valid = 1'b1;
        coin_value = 4'd5;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        coin_value = '0;
        cancel     = 1'b0;
        check("t8_busy", 32'(busy), 1);
        wait_idle(n);
        check("t8_cycles", 32'(n), 10);
        check("t8_pulses", 32'(pulse_cnt - base), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
